// File: rtl/lcd_hd44780_drv_if.sv
// Host-side bus of the HD44780 write driver: request in, LCD pins and status out.
// DATA_W sets the LCD data bus width (8 or 4).
interface lcd_hd44780_drv_if #(
  parameter int DATA_W = 8
);
  logic              start;
  logic              cd;
  logic [7:0]        data;
  logic [DATA_W-1:0] lcd_data;
  logic              rs;
  logic              rw;
  logic              en;
  logic              busy;
  logic              done_tick;
  logic              drop_tick;

  modport master (
    output start, cd, data,
    input  lcd_data, rs, rw, en,
    input  busy, done_tick, drop_tick
  );

  modport slave (
    input  start, cd, data,
    output lcd_data, rs, rw, en,
    output busy, done_tick, drop_tick
  );
endinterface

// File: rtl/lcd_hd44780_drv.sv
// HD44780 single-byte write driver: 8- or 4-bit bus, enable strobe,
// hold and settle timing, long settle after clear/home, busy/done/drop status.
module lcd_hd44780_drv #(
  parameter int DATA_W      = 8,
  parameter int EN_HIGH_CYC = 25,
  parameter int HOLD_CYC    = 50,
  parameter int SETTLE_CYC  = 2500,
  parameter int LONG_CYC    = 80000,
  parameter int CNT_W       = 17
) (
  input logic              clk,
  input logic              rst,
  lcd_hd44780_drv_if.slave bus
);

  if (DATA_W != 8 && DATA_W != 4) begin : g_bad_w
    $error("lcd_hd44780_drv: DATA_W must be 4 or 8");
  end
  if (EN_HIGH_CYC < 1 || HOLD_CYC < 1 ||
      SETTLE_CYC < 1 || LONG_CYC < 1) begin : g_bad_cyc
    $error("lcd_hd44780_drv: all *_CYC must be >= 1");
  end
  if ((EN_HIGH_CYC - 1) >= (1 << CNT_W) ||
      (HOLD_CYC - 1)    >= (1 << CNT_W) ||
      (SETTLE_CYC - 1)  >= (1 << CNT_W) ||
      (LONG_CYC - 1)    >= (1 << CNT_W)) begin : g_bad_cnt
    $error("lcd_hd44780_drv: CNT_W too small");
  end

  localparam logic [CNT_W-1:0] EH_LAST = CNT_W'(EN_HIGH_CYC - 1);
  localparam logic [CNT_W-1:0] HO_LAST = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] ST_LAST = CNT_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] LG_LAST = CNT_W'(LONG_CYC - 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    EN_HI,
    EN_LO,
    SETTLE,
    DONE
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] lo_q, lo_d;
  logic [DATA_W-1:0] lcd_q, lcd_d;
  logic              long_q, long_d;
  logic              nib_q, nib_d;
  logic              rs_q, rs_d;
  logic              en_q, en_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              drop_q, drop_d;
  logic              accept;
  logic              second;

  assign accept = (state_q == IDLE) && bus.start;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.start) state_d = LOAD;
      LOAD:    state_d = EN_HI;
      EN_HI:   if (cnt_q == EH_LAST) state_d = EN_LO;
      EN_LO: begin
        if (cnt_q == HO_LAST)
          state_d = (DATA_W == 4 && !nib_q) ? LOAD : SETTLE;
      end
      SETTLE: begin
        if (cnt_q == (long_q ? LG_LAST : ST_LAST))
          state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign second = (state_q == EN_LO) && (state_d == LOAD);

  always_comb begin
    cnt_d  = cnt_q + 1'b1;
    lcd_d  = lcd_q;
    rs_d   = rs_q;
    lo_d   = lo_q;
    long_d = long_q;
    nib_d  = nib_q;
    if (state_d != state_q || state_d == IDLE)
      cnt_d = '0;
    // The first beat leaves straight from the input so LOAD already shows it.
    if (accept) begin
      lcd_d  = bus.data[7 -: DATA_W];
      rs_d   = bus.cd;
      lo_d   = bus.data[DATA_W-1:0];
      long_d = !bus.cd && (bus.data[7:2] == 6'd0) &&
               (bus.data[1:0] != 2'd0);
      nib_d  = 1'b0;
    end else if (second) begin
      lcd_d = lo_q;
      nib_d = 1'b1;
    end
    en_d   = (state_d == EN_HI);
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
    drop_d = (state_q != IDLE) && bus.start;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      lo_q    <= '0;
      lcd_q   <= '0;
      long_q  <= 1'b0;
      nib_q   <= 1'b0;
      rs_q    <= 1'b0;
      en_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lo_q    <= lo_d;
      lcd_q   <= lcd_d;
      long_q  <= long_d;
      nib_q   <= nib_d;
      rs_q    <= rs_d;
      en_q    <= en_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      drop_q  <= drop_d;
    end
  end

  assign bus.lcd_data  = lcd_q;
  assign bus.rs        = rs_q;
  assign bus.rw        = 1'b0;
  assign bus.en        = en_q;
  assign bus.busy      = busy_q;
  assign bus.done_tick = done_q;
  assign bus.drop_tick = drop_q;

endmodule

// File: tb/tb_lcd_hd44780_drv.sv
// Directed bench for lcd_hd44780_drv: 8-bit and 4-bit instances,
// per-cycle traces, latency table, held start, and async reset mid-strobe.
module tb_lcd_hd44780_drv;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  lcd_hd44780_drv_if #(.DATA_W(8)) b8 ();
  lcd_hd44780_drv_if #(.DATA_W(4)) b4 ();

  lcd_hd44780_drv #(
    .DATA_W(8), .EN_HIGH_CYC(2), .HOLD_CYC(3),
    .SETTLE_CYC(4), .LONG_CYC(10), .CNT_W(17)
  ) u8 (.clk(clk), .rst(rst), .bus(b8.slave));

  lcd_hd44780_drv #(
    .DATA_W(4), .EN_HIGH_CYC(2), .HOLD_CYC(3),
    .SETTLE_CYC(4), .LONG_CYC(10), .CNT_W(17)
  ) u4 (.clk(clk), .rst(rst), .bus(b4.slave));

  int npass = 0;
  int ntot  = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    ntot++;
    if (act !== exp)
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    else
      npass++;
  endtask

  function automatic logic [7:0] o_lcd(bit w4);
    return w4 ? {4'h0, b4.lcd_data} : b8.lcd_data;
  endfunction
  function automatic logic o_rs(bit w4);
    return w4 ? b4.rs : b8.rs;
  endfunction
  function automatic logic o_en(bit w4);
    return w4 ? b4.en : b8.en;
  endfunction
  function automatic logic o_busy(bit w4);
    return w4 ? b4.busy : b8.busy;
  endfunction
  function automatic logic o_done(bit w4);
    return w4 ? b4.done_tick : b8.done_tick;
  endfunction

  task automatic drive(input bit w4, input logic [7:0] d,
                       input logic c, input logic s);
    if (w4) begin
      b4.data = d; b4.cd = c; b4.start = s;
    end else begin
      b8.data = d; b8.cd = c; b8.start = s;
    end
  endtask

  // rw must stay low and done_tick never lasts two cycles
  logic pd8 = 1'b0;
  logic pd4 = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      chk("rw8", b8.rw, 1'b0);
      chk("rw4", b4.rw, 1'b0);
      if (b8.done_tick) chk("done_width8", pd8, 1'b0);
      if (b4.done_tick) chk("done_width4", pd4, 1'b0);
    end
    pd8 <= b8.done_tick;
    pd4 <= b4.done_tick;
  end

  typedef struct {
    logic [7:0] lcd;
    logic       rs;
    logic       en;
    logic       busy;
    logic       done;
  } vec_t;

  typedef struct {
    bit         w4;
    logic [7:0] d;
    logic       cd;
    int         t;
  } txn_t;

  vec_t v8[1:12];
  vec_t v4[1:18];
  txn_t tx[9];

  task automatic run_trace(input bit w4, input logic [7:0] d,
                           input logic c, input int n);
    vec_t e;
    @(negedge clk);
    drive(w4, d, c, 1'b1);
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      if (k == 1) drive(w4, d, c, 1'b0);
      e = w4 ? v4[k] : v8[k];
      chk($sformatf("tr%0d_lcd_c%0d", w4, k), o_lcd(w4), e.lcd);
      chk($sformatf("tr%0d_rs_c%0d", w4, k), o_rs(w4), e.rs);
      chk($sformatf("tr%0d_en_c%0d", w4, k), o_en(w4), e.en);
      chk($sformatf("tr%0d_busy_c%0d", w4, k), o_busy(w4), e.busy);
      chk($sformatf("tr%0d_done_c%0d", w4, k), o_done(w4), e.done);
    end
  endtask

  task automatic run_txn(input txn_t t, input int idx);
    int cyc;
    int tdone;
    int ens;
    logic [7:0] lfin;
    cyc = 1; tdone = -1; ens = 0;
    @(negedge clk);
    drive(t.w4, t.d, t.cd, 1'b1);
    @(negedge clk);
    drive(t.w4, t.d, t.cd, 1'b0);
    while (cyc <= 200) begin
      if (o_en(t.w4)) ens++;
      if (o_done(t.w4)) begin
        tdone = cyc;
        break;
      end
      @(negedge clk);
      cyc++;
    end
    lfin = t.w4 ? {4'h0, t.d[3:0]} : t.d;
    chk($sformatf("txn%0d_latency", idx), tdone, t.t);
    chk($sformatf("txn%0d_en_cycles", idx), ens, t.w4 ? 4 : 2);
    @(negedge clk);
    chk($sformatf("txn%0d_busy_after", idx), o_busy(t.w4), 1'b0);
    chk($sformatf("txn%0d_lcd_hold", idx), o_lcd(t.w4), lfin);
    chk($sformatf("txn%0d_rs_hold", idx), o_rs(t.w4), t.cd);
  endtask

  initial begin
    int dcnt;
    int drcnt;
    int dw;
    int tfin;

    for (int k = 1; k <= 12; k++) begin
      v8[k].lcd  = 8'h41;
      v8[k].rs   = 1'b1;
      v8[k].en   = (k == 2 || k == 3);
      v8[k].busy = (k <= 11);
      v8[k].done = (k == 11);
    end
    for (int k = 1; k <= 18; k++) begin
      v4[k].lcd  = (k <= 6) ? 8'h04 : 8'h01;
      v4[k].rs   = 1'b1;
      v4[k].en   = (k == 2 || k == 3 || k == 8 || k == 9);
      v4[k].busy = (k <= 17);
      v4[k].done = (k == 17);
    end
    tx[0] = '{w4: 1'b0, d: 8'h41, cd: 1'b1, t: 11};
    tx[1] = '{w4: 1'b1, d: 8'h41, cd: 1'b1, t: 17};
    tx[2] = '{w4: 1'b0, d: 8'h01, cd: 1'b0, t: 17};
    tx[3] = '{w4: 1'b0, d: 8'h01, cd: 1'b1, t: 11};
    tx[4] = '{w4: 1'b0, d: 8'h02, cd: 1'b0, t: 17};
    tx[5] = '{w4: 1'b0, d: 8'h03, cd: 1'b0, t: 17};
    tx[6] = '{w4: 1'b0, d: 8'h04, cd: 1'b0, t: 11};
    tx[7] = '{w4: 1'b1, d: 8'h01, cd: 1'b0, t: 23};
    tx[8] = '{w4: 1'b0, d: 8'h00, cd: 1'b0, t: 11};

    drive(1'b0, 8'h00, 1'b0, 1'b0);
    drive(1'b1, 8'h00, 1'b0, 1'b0);

    #12;
    chk("rst_lcd8", b8.lcd_data, 8'h00);
    chk("rst_lcd4", b4.lcd_data, 4'h0);
    chk("rst_rs8", b8.rs, 1'b0);
    chk("rst_en8", b8.en, 1'b0);
    chk("rst_busy8", b8.busy, 1'b0);
    chk("rst_done8", b8.done_tick, 1'b0);
    chk("rst_drop8", b8.drop_tick, 1'b0);
    chk("rst_busy4", b4.busy, 1'b0);
    chk("rst_rw4", b4.rw, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    run_trace(1'b0, 8'h41, 1'b1, 12);
    run_trace(1'b1, 8'h41, 1'b1, 18);

    for (int i = 0; i < 9; i++) run_txn(tx[i], i);

    // start held high for cycles 0..29 on the 8-bit instance
    dcnt = 0; drcnt = 0; dw = 0;
    @(negedge clk);
    drive(1'b0, 8'h30, 1'b0, 1'b1);
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (c == 30) drive(1'b0, 8'h30, 1'b0, 1'b0);
      if (b8.done_tick) begin
        dcnt++;
        if (c <= 29) dw++;
      end
      if (b8.drop_tick) drcnt++;
      if (c == 1)  chk("hold_drop_c1", b8.drop_tick, 1'b0);
      if (c == 11) chk("hold_done_c11", b8.done_tick, 1'b1);
      if (c == 12) chk("hold_busy_c12", b8.busy, 1'b0);
      if (c == 12) chk("hold_drop_c12", b8.drop_tick, 1'b1);
      if (c == 13) chk("hold_busy_c13", b8.busy, 1'b1);
      if (c == 13) chk("hold_drop_c13", b8.drop_tick, 1'b0);
      if (c == 23) chk("hold_done_c23", b8.done_tick, 1'b1);
      if (c == 24) chk("hold_busy_c24", b8.busy, 1'b0);
      if (c == 30) chk("hold_drop_c30", b8.drop_tick, 1'b1);
      if (c == 31) chk("hold_drop_c31", b8.drop_tick, 1'b0);
      if (c == 35) chk("hold_done_c35", b8.done_tick, 1'b1);
      if (c == 36) chk("hold_busy_c36", b8.busy, 1'b0);
    end
    chk("hold_done_in_window", dw, 2);
    chk("hold_done_total", dcnt, 3);
    chk("hold_drop_total", drcnt, 27);

    // async reset in the middle of the enable strobe
    @(negedge clk);
    drive(1'b0, 8'h55, 1'b1, 1'b1);
    @(negedge clk);
    drive(1'b0, 8'h55, 1'b1, 1'b0);
    @(negedge clk);
    chk("arst_pre_en", b8.en, 1'b1);
    #2 rst = 1'b0;
    #1;
    chk("arst_en", b8.en, 1'b0);
    chk("arst_busy", b8.busy, 1'b0);
    chk("arst_rs", b8.rs, 1'b0);
    chk("arst_lcd", b8.lcd_data, 8'h00);
    @(negedge clk);
    rst = 1'b1;
    dcnt = 0; dw = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (b8.done_tick) dcnt++;
      if (b8.busy) dw++;
    end
    chk("arst_no_done", dcnt, 0);
    chk("arst_idle", dw, 0);
    run_txn(tx[0], 9);

    tfin = 0;
    while (b8.busy || b4.busy) begin
      @(negedge clk);
      tfin++;
      if (tfin > 200) begin
        chk("final_idle_timeout", 1, 0);
        break;
      end
    end

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got 1, expected 0");
    $fatal(1, "timeout");
  end

endmodule
